// File: rtl/round_robin_dispatcher_pkg.sv
// round_robin_dispatcher_pkg: shared helpers for the round-robin dispatcher slice.
package round_robin_dispatcher_pkg;

   // Bits needed to index n channels, never less than one.
   function automatic int unsigned index_width(input int unsigned n);
      for (int unsigned w = 1; w < 32; w++) begin
         if ((32'd1 << w) >= n) return w;
      end
      return 32;
   endfunction

endpackage

// File: rtl/round_robin_dispatcher_select.sv
// round_robin_dispatcher_select: picks the target channel for the buffered word.
// ROUND_ROBIN_DISPATCHER_SKIP_BUSY_EN selects work-conserving instead of strict rotation.
module round_robin_dispatcher_select #(
   parameter int unsigned SIZE      = 4,
   parameter int unsigned SIZE_LOG2 = 2
) (
   input  logic [SIZE_LOG2-1:0] pointer,
   input  logic                 buffer_valid,
`ifdef ROUND_ROBIN_DISPATCHER_SKIP_BUSY_EN
   input  logic [SIZE-1:0]      output_ready,
`endif
   output logic [SIZE-1:0]      output_valid,
   output logic [SIZE_LOG2-1:0] served
);

`ifdef ROUND_ROBIN_DISPATCHER_SKIP_BUSY_EN
   logic                 found;
   logic [SIZE_LOG2:0]   slot;

   // Wrapped upward scan from pointer; same grant as rotate/priority/rotate-back.
   always_comb begin
      output_valid = '0;
      served       = pointer;
      found        = 1'b0;
      slot         = '0;
      for (int unsigned k = 0; k < SIZE; k++) begin
         slot = {1'b0, pointer} + (SIZE_LOG2+1)'(k);
         if (slot >= (SIZE_LOG2+1)'(SIZE)) slot = slot - (SIZE_LOG2+1)'(SIZE);
         if (!found && output_ready[slot[SIZE_LOG2-1:0]]) begin
            found                               = 1'b1;
            served                              = slot[SIZE_LOG2-1:0];
            output_valid[slot[SIZE_LOG2-1:0]]   = buffer_valid;
         end
      end
   end
`else
   always_comb begin
      output_valid          = '0;
      output_valid[pointer] = buffer_valid;
      served                = pointer;
   end
`endif

endmodule

// File: rtl/round_robin_dispatcher.sv
// round_robin_dispatcher: fans one valid/ready stream out to SIZE channels in rotating order.
// Define ROUND_ROBIN_DISPATCHER_SKIP_BUSY_EN for work-conserving (skip busy channel) selection.
module round_robin_dispatcher
   import round_robin_dispatcher_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SIZE  = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             input_valid,
   input  logic [WIDTH-1:0] input_data,
   output logic             input_ready,
   output logic [SIZE-1:0]  output_valid,
   output logic [WIDTH-1:0] output_data,
   input  logic [SIZE-1:0]  output_ready
);

   localparam int unsigned SIZE_LOG2 = index_width(SIZE);

   logic                 buffer_valid;
   logic [WIDTH-1:0]     buffer_data;
   logic [SIZE_LOG2-1:0] pointer;
   logic [SIZE_LOG2-1:0] served;
   logic [SIZE_LOG2-1:0] pointer_next;
   logic                 input_transfer;
   logic                 output_transfer;

   round_robin_dispatcher_select #(
      .SIZE      (SIZE),
      .SIZE_LOG2 (SIZE_LOG2)
   ) u_select (
      .pointer      (pointer),
      .buffer_valid (buffer_valid),
`ifdef ROUND_ROBIN_DISPATCHER_SKIP_BUSY_EN
      .output_ready (output_ready),
`endif
      .output_valid (output_valid),
      .served       (served)
   );

   assign output_data     = buffer_data;
   assign output_transfer = |(output_valid & output_ready);
   assign input_ready     = !buffer_valid | output_transfer;
   assign input_transfer  = input_valid & input_ready;
   assign pointer_next    = (served == SIZE_LOG2'(SIZE-1)) ? '0 : served + SIZE_LOG2'(1);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         buffer_valid <= 1'b0;
         buffer_data  <= '0;
         pointer      <= '0;
      end else begin
         if (input_transfer) begin
            buffer_valid <= 1'b1;
            buffer_data  <= input_data;
         end else if (output_transfer) begin
            buffer_valid <= 1'b0;
         end
         if (output_transfer) pointer <= pointer_next;
      end
   end

endmodule
